sobel_frame_sched: RTL and testbench
====================================

Name: sobel_frame_sched

Overview:
Frame-level scheduler for the real-time Sobel path. It sits between the video timing generator and the line-buffer/Sobel datapath. It tracks frame, line and pixel position from video_vs/video_de and rotates the 3-line buffer write index. It flags when the 3x3 window is valid, and applies register-side config (mode, threshold) only at frame boundaries, so a frame is never processed with mixed settings.

Parameters:
H_DISP, 1280, active pixels per line
V_DISP, 720, active lines per frame
CNT_W, 11, width of x/y counters
FRAME_W, 16, width of frame counter
MODE_RST, 2'd2, mode after reset (0 bypass, 1 gray, 2 edge, 3 reserved->treated as bypass)
THR_RST, 8'd64, threshold after reset

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
video_vs  in  1  vertical sync, active-low (frame starts on falling edge)
video_de  in  1  active-video enable
cfg_valid  in  1  new config offered
cfg_ready  out  1  pending slot free
cfg_mode  in  2  requested mode
cfg_thresh  in  8  requested edge threshold
err_clr  in  1  clears sticky errors
act_mode  out  2  mode in force for current frame
act_thresh  out  8  threshold in force for current frame
sof  out  1  start-of-frame pulse
eol  out  1  end-of-line pulse
lb_wr_sel  out  2  line buffer being written (0,1,2)
pix_x  out  CNT_W  x of current active pixel
pix_y  out  CNT_W  y of current active pixel
win_valid  out  1  3x3 window complete at this pixel
frame_active  out  1  inside a frame (VBLANK excluded)
frame_cnt  out  FRAME_W  completed frames, wraps
err_hlen  out  1  sticky: line length != H_DISP
err_vlen  out  1  sticky: line count != V_DISP

Behaviour:
- All outputs registered, 1 cycle after the inputs that cause them. Reset values:
  - all pulses, errors, pix_x, pix_y, lb_wr_sel, frame_cnt, frame_active: 0
  - cfg_ready: 1
  - act_mode: MODE_RST; act_thresh: THR_RST
- Edge detection uses registered vs_d/de_d:
  - vs_fall = vs_d & ~video_vs
  - de_rise = ~de_d & video_de
  - de_fall = de_d & ~video_de
- FSM states: IDLE, VBLANK, LINE, HBLANK.
  - IDLE: after reset; video_de ignored; leaves only on vs_fall -> VBLANK.
  - VBLANK: de_rise -> LINE.
  - LINE: de_fall -> HBLANK.
  - HBLANK: de_rise -> LINE.
  - vs_fall in any state -> VBLANK. vs_fall has priority over every de event in the same cycle.
- On vs_fall:
  - sof=1; lb_wr_sel:=0; y:=0; x:=0.
  - If a pending config exists: act_* := pending and pending cleared.
  - If not the first frame since reset: frame_cnt+=1; err_vlen set if the line count != V_DISP.
  - vs_fall during LINE is a truncated line: no eol, err_hlen not evaluated.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready; the value is stored in a single pending slot and cfg_ready drops.
  - cfg_ready returns 1 the cycle after the slot is consumed at vs_fall.
  - A transfer in the same cycle as vs_fall is not applied this frame; it waits for the next vs_fall.
- In LINE, each de-high cycle: pix_x = x, pix_y = y, then x+=1. x saturates at 2^CNT_W-1.
- On de_fall:
  - eol=1; err_hlen set if x != H_DISP; x:=0; y+=1.
  - lb_wr_sel advances 0->1->2->0.
- win_valid = de-high pixel with x>=2 and y>=2; the window centre is (x-1, y-1).
- frame_active = 1 in LINE/HBLANK, 0 in IDLE/VBLANK.
- Error flags:
  - err_clr clears both flags.
  - A set event in the same cycle as err_clr wins (flag stays 1).

Decomposition:
- Shared package sobel_pkg holds:
  - mode encoding constants MODE_BYPASS/GRAY/EDGE
  - state enum localparams
  - H_DISP/V_DISP defaults shared with the timing generator and line buffers
- One natural sub-module: sobel_cfg_shadow (pending slot + frame-boundary apply + cfg_ready).

Test Plan:
- Use H_DISP=8, V_DISP=4 throughout.
- Reset then 3 clean frames -> sof once per frame; 4 eol per frame; lb_wr_sel sequence 0,1,2,0; frame_cnt 0,1,2; no errors.
- Line 2 pixels x=0..7 -> win_valid high exactly at x=2..7 (6 cycles); low on lines 0 and 1.
- cfg_valid mode=1, thr=100 mid-frame -> cfg_ready drops next cycle; act_mode/act_thresh unchanged until next vs_fall, then 1/100; cfg_ready back to 1.
- cfg transfer in the same cycle as vs_fall -> applied at the following vs_fall, not the current one.
- 7-pixel line -> err_hlen=1 after that eol. 3-line frame -> err_vlen=1 at next vs_fall. err_clr clears both; err_clr coincident with a new error leaves the flag 1.
- sys_rst asserted mid-LINE -> next cycle all outputs at reset values and state IDLE; de ignored until next vs_fall; no err_vlen on the first frame after reset.

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and types for the Sobel frame path
// Holds the mode encodings, the frame-scheduler state type and the default
// active-video geometry shared with the timing generator and line buffers.
package sobel_pkg;

    localparam int H_DISP_DEF = 1280;
    localparam int V_DISP_DEF = 720;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_GRAY   = 2'd1;
    localparam logic [1:0] MODE_EDGE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_LINE   = 2'd2,
        ST_HBLANK = 2'd3
    } sched_state_t;

    // Encoding 3 is reserved; the datapath runs it as bypass.
    function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
        return (m == 2'd3) ? MODE_BYPASS : m;
    endfunction

endpackage

// File: rtl/sobel_cfg_if.sv
// rtl/sobel_cfg_if.sv - config offer handshake between register side and scheduler
// Signals: cfg_valid/cfg_mode/cfg_thresh from the register side, cfg_ready back.
interface sobel_cfg_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_thresh;

    modport master (output cfg_valid, output cfg_mode, output cfg_thresh, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mode, input cfg_thresh, output cfg_ready);
endinterface

// File: rtl/sobel_cfg_shadow.sv
// rtl/sobel_cfg_shadow.sv - single-slot pending config applied only at frame start
// Ports: pixel_clk, sys_rst (sync, active-high); frame_start (vs falling edge);
//   cfg_valid/cfg_mode/cfg_thresh in, cfg_ready out; act_mode/act_thresh in force.
module sobel_cfg_shadow
    import sobel_pkg::*;
#(
    parameter logic [1:0] MODE_RST = MODE_EDGE,
    parameter logic [7:0] THR_RST  = 8'd64
) (
    input  logic       pixel_clk,
    input  logic       sys_rst,
    input  logic       frame_start,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_thresh,
    output logic       cfg_ready,
    output logic [1:0] act_mode,
    output logic [7:0] act_thresh
);

    logic       pend_q, pend_d;
    logic [1:0] pmode_q, pmode_d;
    logic [7:0] pthr_q, pthr_d;
    logic [1:0] amode_q, amode_d;
    logic [7:0] athr_q, athr_d;
    logic       ready_q;

    always_comb begin
        pend_d  = pend_q;
        pmode_d = pmode_q;
        pthr_d  = pthr_q;
        amode_d = amode_q;
        athr_d  = athr_q;
        if (frame_start && pend_q) begin
            amode_d = mode_sanitize(pmode_q);
            athr_d  = pthr_q;
            pend_d  = 1'b0;
        end
        // Only possible while the slot is empty, so it never collides with the
        // apply above; an offer taken at frame_start waits for the next frame.
        if (cfg_valid && ready_q) begin
            pend_d  = 1'b1;
            pmode_d = cfg_mode;
            pthr_d  = cfg_thresh;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            pend_q  <= 1'b0;
            pmode_q <= '0;
            pthr_q  <= '0;
            amode_q <= MODE_RST;
            athr_q  <= THR_RST;
            ready_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            pmode_q <= pmode_d;
            pthr_q  <= pthr_d;
            amode_q <= amode_d;
            athr_q  <= athr_d;
            ready_q <= ~pend_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign act_mode   = amode_q;
    assign act_thresh = athr_q;

endmodule

// File: rtl/sobel_frame_sched.sv
// rtl/sobel_frame_sched.sv - frame/line/pixel tracking and frame-boundary config for the Sobel path
// Ports: pixel_clk, sys_rst (sync, active-high); video_vs (active-low), video_de;
//   cfg (config handshake, slave side); err_clr; act_mode/act_thresh; sof/eol pulses;
//   lb_wr_sel; pix_x/pix_y/win_valid; frame_active; frame_cnt; sticky err_hlen/err_vlen.
module sobel_frame_sched
    import sobel_pkg::*;
#(
    parameter int         H_DISP   = H_DISP_DEF,
    parameter int         V_DISP   = V_DISP_DEF,
    parameter int         CNT_W    = 11,
    parameter int         FRAME_W  = 16,
    parameter logic [1:0] MODE_RST = MODE_EDGE,
    parameter logic [7:0] THR_RST  = 8'd64
) (
    input  logic               pixel_clk,
    input  logic               sys_rst,
    input  logic               video_vs,
    input  logic               video_de,
    sobel_cfg_if.slave         cfg,
    input  logic               err_clr,
    output logic [1:0]         act_mode,
    output logic [7:0]         act_thresh,
    output logic               sof,
    output logic               eol,
    output logic [1:0]         lb_wr_sel,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               win_valid,
    output logic               frame_active,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               err_hlen,
    output logic               err_vlen
);

    localparam logic [CNT_W-1:0] X_MAX = '1;
    localparam logic [CNT_W-1:0] H_LEN = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_LEN = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(2);

    sched_state_t       state_q;
    logic               vs_d_q, de_d_q, first_q;
    logic [CNT_W-1:0]   x_q, y_q, pix_x_q, pix_y_q;
    logic [1:0]         lb_q;
    logic               sof_q, eol_q, win_q, fa_q, eh_q, ev_q;
    logic [FRAME_W-1:0] fc_q;

    logic vs_fall, de_rise, de_fall, pix_en, line_end, set_hlen, set_vlen;
    logic cfg_ready_w;

    assign vs_fall = vs_d_q & ~video_vs;
    assign de_rise = ~de_d_q & video_de;
    assign de_fall = de_d_q & ~video_de;

    // The first pixel of a line arrives on de_rise while still in a blanking
    // state, so it is counted before the FSM reaches LINE. vs_fall pre-empts.
    assign pix_en   = ~vs_fall & video_de &
                      ((state_q == ST_LINE) |
                       (de_rise & ((state_q == ST_VBLANK) | (state_q == ST_HBLANK))));
    assign line_end = ~vs_fall & de_fall & (state_q == ST_LINE);
    assign set_hlen = line_end & (x_q != H_LEN);
    assign set_vlen = vs_fall & ~first_q & (y_q != V_LEN);

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            vs_d_q  <= 1'b1;
            de_d_q  <= 1'b0;
            first_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            lb_q    <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            win_q   <= 1'b0;
            fa_q    <= 1'b0;
            eh_q    <= 1'b0;
            ev_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            vs_d_q <= video_vs;
            de_d_q <= video_de;
            sof_q  <= vs_fall;
            eol_q  <= line_end;
            win_q  <= 1'b0;
            // A set in the same cycle as err_clr keeps the flag.
            eh_q   <= set_hlen | (eh_q & ~err_clr);
            ev_q   <= set_vlen | (ev_q & ~err_clr);
            if (vs_fall) begin
                state_q <= ST_VBLANK;
                fa_q    <= 1'b0;
                lb_q    <= '0;
                x_q     <= '0;
                y_q     <= '0;
                first_q <= 1'b0;
                if (!first_q) begin
                    fc_q <= fc_q + 1'b1;
                end
            end else begin
                case (state_q)
                    ST_VBLANK, ST_HBLANK: begin
                        if (de_rise) begin
                            state_q <= ST_LINE;
                            fa_q    <= 1'b1;
                        end
                    end
                    ST_LINE: begin
                        if (de_fall) begin
                            state_q <= ST_HBLANK;
                        end
                    end
                    default: begin
                    end
                endcase
                if (pix_en) begin
                    pix_x_q <= x_q;
                    pix_y_q <= y_q;
                    win_q   <= (x_q >= WIN_MIN) && (y_q >= WIN_MIN);
                    if (x_q != X_MAX) begin
                        x_q <= x_q + 1'b1;
                    end
                end
                if (line_end) begin
                    x_q  <= '0;
                    y_q  <= y_q + 1'b1;
                    lb_q <= (lb_q == 2'd2) ? 2'd0 : lb_q + 2'd1;
                end
            end
        end
    end

    sobel_cfg_shadow #(
        .MODE_RST (MODE_RST),
        .THR_RST  (THR_RST)
    ) u_cfg_shadow (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .frame_start (vs_fall),
        .cfg_valid   (cfg.cfg_valid),
        .cfg_mode    (cfg.cfg_mode),
        .cfg_thresh  (cfg.cfg_thresh),
        .cfg_ready   (cfg_ready_w),
        .act_mode    (act_mode),
        .act_thresh  (act_thresh)
    );

    assign cfg.cfg_ready = cfg_ready_w;
    assign sof           = sof_q;
    assign eol           = eol_q;
    assign lb_wr_sel     = lb_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign win_valid     = win_q;
    assign frame_active  = fa_q;
    assign frame_cnt     = fc_q;
    assign err_hlen      = eh_q;
    assign err_vlen      = ev_q;

endmodule

// File: tb/tb_sobel_frame_sched.sv
// tb/tb_sobel_frame_sched.sv - self-checking bench for sobel_frame_sched
module tb_sobel_frame_sched;
    import sobel_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 11;
    localparam int FW = 16;

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic          sys_rst, video_vs, video_de, err_clr;
    logic [1:0]    act_mode, lb_wr_sel;
    logic [7:0]    act_thresh;
    logic          sof, eol, win_valid, frame_active, err_hlen, err_vlen;
    logic [CW-1:0] pix_x, pix_y;
    logic [FW-1:0] frame_cnt;

    sobel_cfg_if cfg_bus ();

    sobel_frame_sched #(
        .H_DISP(H), .V_DISP(V), .CNT_W(CW), .FRAME_W(FW),
        .MODE_RST(2'd2), .THR_RST(8'd64)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(video_vs), .video_de(video_de),
        .cfg(cfg_bus), .err_clr(err_clr),
        .act_mode(act_mode), .act_thresh(act_thresh), .sof(sof), .eol(eol),
        .lb_wr_sel(lb_wr_sel), .pix_x(pix_x), .pix_y(pix_y), .win_valid(win_valid),
        .frame_active(frame_active), .frame_cnt(frame_cnt),
        .err_hlen(err_hlen), .err_vlen(err_vlen)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: position counters as plain integers, driven by the
    // input edges the bench applies.
    int m_valid = 0;
    int p_vs, p_de, armed, first, in_line, in_frame, px, ln, pend, pm, pt;
    int m_sof, m_eol, m_win, m_lb, m_fa, m_fc, m_eh, m_ev, m_rdy, m_am, m_at;
    int m_pix, m_px, m_py;

    task automatic model_step();
        int fall_vs, rise, fall_de, sh, sv, xfer;
        if (sys_rst) begin
            m_valid = 1; p_vs = 1; p_de = 0; armed = 0; first = 1; in_line = 0; in_frame = 0;
            px = 0; ln = 0; pend = 0; pm = 0; pt = 0;
            m_sof = 0; m_eol = 0; m_win = 0; m_lb = 0; m_fa = 0; m_fc = 0; m_eh = 0; m_ev = 0;
            m_rdy = 1; m_am = 2; m_at = 64; m_pix = 1; m_px = 0; m_py = 0;
        end else if (m_valid != 0) begin
            fall_vs = int'(p_vs == 1 && video_vs == 1'b0);
            rise    = int'(p_de == 0 && video_de == 1'b1);
            fall_de = int'(p_de == 1 && video_de == 1'b0);
            sh = 0; sv = 0; m_sof = 0; m_eol = 0; m_win = 0; m_pix = 0;
            xfer = int'(cfg_bus.cfg_valid == 1'b1 && m_rdy == 1);
            if (fall_vs != 0) begin
                m_sof = 1; m_lb = 0;
                if (first == 0) begin
                    m_fc = (m_fc + 1) % 65536;
                    if (ln != V) sv = 1;
                end
                first = 0; armed = 1; in_line = 0; in_frame = 0; px = 0; ln = 0;
                if (pend != 0) begin
                    m_am = (pm == 3) ? 0 : pm; m_at = pt; pend = 0;
                end
            end else if (armed != 0) begin
                if (video_de == 1'b1 && (in_line != 0 || rise != 0)) begin
                    m_pix = 1; m_px = px; m_py = ln;
                    m_win = int'(px >= 2 && ln >= 2);
                    if (px < 2047) px++;
                    in_line = 1; in_frame = 1;
                end else if (fall_de != 0 && in_line != 0) begin
                    m_eol = 1;
                    if (px != H) sh = 1;
                    px = 0; ln++; m_lb = (m_lb + 1) % 3; in_line = 0;
                end
            end
            if (xfer != 0) begin
                pend = 1; pm = int'(cfg_bus.cfg_mode); pt = int'(cfg_bus.cfg_thresh);
            end
            m_rdy = (pend != 0) ? 0 : 1;
            m_fa = in_frame;
            m_eh = int'(sh != 0 || (m_eh != 0 && err_clr == 1'b0));
            m_ev = int'(sv != 0 || (m_ev != 0 && err_clr == 1'b0));
            p_vs = int'(video_vs); p_de = int'(video_de);
        end
    endtask

    initial begin
        forever begin
            @(negedge pixel_clk);
            if (m_valid != 0) begin
                chk("sof", int'(sof), m_sof);
                chk("eol", int'(eol), m_eol);
                chk("win_valid", int'(win_valid), m_win);
                chk("lb_wr_sel", int'(lb_wr_sel), m_lb);
                chk("frame_active", int'(frame_active), m_fa);
                chk("frame_cnt", int'(frame_cnt), m_fc);
                chk("err_hlen", int'(err_hlen), m_eh);
                chk("err_vlen", int'(err_vlen), m_ev);
                chk("cfg_ready", int'(cfg_bus.cfg_ready), m_rdy);
                chk("act_mode", int'(act_mode), m_am);
                chk("act_thresh", int'(act_thresh), m_at);
                if (m_pix != 0) begin
                    chk("pix_x", int'(pix_x), m_px);
                    chk("pix_y", int'(pix_y), m_py);
                end
            end
            model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic drive(input logic vs, input logic de);
        video_vs = vs;
        video_de = de;
        tick(1);
    endtask

    // One line of len pixels followed by 3 blanking cycles.
    task automatic line(input int len, input int exp_lb, output int wins);
        wins = 0;
        for (int i = 0; i < len; i++) begin
            drive(1'b1, 1'b1);
            if (win_valid) wins++;
            if (i == 0) chk("lb_at_line_start", int'(lb_wr_sel), exp_lb);
        end
        drive(1'b1, 1'b0);
        chk("eol_pulse", int'(eol), 1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
    endtask

    task automatic vs_rest();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_sof"}, int'(sof), 0);
        chk({tag, "_eol"}, int'(eol), 0);
        chk({tag, "_lb"}, int'(lb_wr_sel), 0);
        chk({tag, "_pix_x"}, int'(pix_x), 0);
        chk({tag, "_pix_y"}, int'(pix_y), 0);
        chk({tag, "_win"}, int'(win_valid), 0);
        chk({tag, "_fa"}, int'(frame_active), 0);
        chk({tag, "_fcnt"}, int'(frame_cnt), 0);
        chk({tag, "_eh"}, int'(err_hlen), 0);
        chk({tag, "_ev"}, int'(err_vlen), 0);
        chk({tag, "_ready"}, int'(cfg_bus.cfg_ready), 1);
        chk({tag, "_mode"}, int'(act_mode), 2);
        chk({tag, "_thr"}, int'(act_thresh), 64);
    endtask

    initial begin
        int w;
        sys_rst = 1'b1; video_vs = 1'b1; video_de = 1'b0; err_clr = 1'b0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_mode = 2'd0; cfg_bus.cfg_thresh = 8'd0;
        tick(3);
        reset_literals("rst");
        sys_rst = 1'b0;

        // IDLE ignores de
        drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        chk("idle_eol", int'(eol), 0);
        chk("idle_fa", int'(frame_active), 0);
        drive(1'b1, 1'b0);

        // three clean frames
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 1'b0);
            chk("frame_sof", int'(sof), 1);
            chk("frame_cnt_at_sof", int'(frame_cnt), f);
            vs_rest();
            chk("sof_once", int'(sof), 0);
            for (int l = 0; l < 4; l++) begin
                line(H, l % 3, w);
                chk("win_count", w, (l >= 2) ? 6 : 0);
            end
        end
        chk("clean_eh", int'(err_hlen), 0);
        chk("clean_ev", int'(err_vlen), 0);

        // config offered mid-frame
        drive(1'b0, 1'b0);
        chk("f4_fcnt", int'(frame_cnt), 3);
        vs_rest();
        line(H, 0, w);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_mode = 2'd1; cfg_bus.cfg_thresh = 8'd100;
        drive(1'b1, 1'b0);
        cfg_bus.cfg_valid = 1'b0;
        chk("cfg_ready_drop", int'(cfg_bus.cfg_ready), 0);
        chk("mode_held", int'(act_mode), 2);
        chk("thr_held", int'(act_thresh), 64);
        for (int l = 1; l < 4; l++) line(H, l % 3, w);
        chk("mode_held_eof", int'(act_mode), 2);
        drive(1'b0, 1'b0);
        chk("mode_applied", int'(act_mode), 1);
        chk("thr_applied", int'(act_thresh), 100);
        chk("cfg_ready_back", int'(cfg_bus.cfg_ready), 1);
        vs_rest();
        for (int l = 0; l < 4; l++) line(H, l % 3, w);

        // config transfer coincident with vs_fall
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_mode = 2'd0; cfg_bus.cfg_thresh = 8'd50;
        drive(1'b0, 1'b0);
        cfg_bus.cfg_valid = 1'b0;
        chk("coinc_mode_not_yet", int'(act_mode), 1);
        chk("coinc_thr_not_yet", int'(act_thresh), 100);
        chk("coinc_ready", int'(cfg_bus.cfg_ready), 0);
        vs_rest();
        for (int l = 0; l < 4; l++) line(H, l % 3, w);
        drive(1'b0, 1'b0);
        chk("coinc_mode_applied", int'(act_mode), 0);
        chk("coinc_thr_applied", int'(act_thresh), 50);
        chk("coinc_ready_back", int'(cfg_bus.cfg_ready), 1);
        vs_rest();

        // short line -> err_hlen
        line(H, 0, w);
        line(H - 1, 1, w);
        chk("short_eh", int'(err_hlen), 1);
        chk("short_ev", int'(err_vlen), 0);
        line(H, 2, w);
        line(H, 0, w);
        err_clr = 1'b1;
        drive(1'b1, 1'b0);
        err_clr = 1'b0;
        chk("clr_eh", int'(err_hlen), 0);

        // 3-line frame -> err_vlen at the following vs_fall
        drive(1'b0, 1'b0);
        chk("full_frame_ev", int'(err_vlen), 0);
        vs_rest();
        for (int l = 0; l < 3; l++) line(H, l % 3, w);
        drive(1'b0, 1'b0);
        chk("short_frame_ev", int'(err_vlen), 1);
        vs_rest();

        // err_clr coincident with a new hlen error
        for (int i = 0; i < H - 1; i++) drive(1'b1, 1'b1);
        err_clr = 1'b1;
        drive(1'b1, 1'b0);
        err_clr = 1'b0;
        chk("clr_vs_set_eh", int'(err_hlen), 1);
        chk("clr_ev", int'(err_vlen), 0);
        drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        for (int l = 1; l < 4; l++) line(H, l % 3, w);
        err_clr = 1'b1;
        drive(1'b1, 1'b0);
        err_clr = 1'b0;
        chk("clr_eh2", int'(err_hlen), 0);

        // reset in the middle of a line
        drive(1'b0, 1'b0);
        vs_rest();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        sys_rst = 1'b1;
        drive(1'b1, 1'b1);
        sys_rst = 1'b0;
        reset_literals("midrst");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        chk("postrst_eol", int'(eol), 0);
        chk("postrst_fa", int'(frame_active), 0);
        drive(1'b1, 1'b0);
        for (int i = 0; i < H; i++) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        chk("postrst_eol2", int'(eol), 0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        chk("postrst_sof", int'(sof), 1);
        chk("postrst_ev", int'(err_vlen), 0);
        chk("postrst_fcnt", int'(frame_cnt), 0);
        vs_rest();
        for (int l = 0; l < 4; l++) line(H, l % 3, w);
        drive(1'b0, 1'b0);
        chk("postrst_fcnt1", int'(frame_cnt), 1);
        chk("postrst_ev1", int'(err_vlen), 0);
        vs_rest();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
